ahb_rom_slave_if: RTL and testbench
===================================

// Module: ahb_rom_slave_if
// PURPOSE
// - AHB-Lite slave front-end sitting directly upstream of the instruction ROM.
// - Decodes AHB address/data phases and drives the ROM's sel_0 / rd_en_rom / address_rom strobes.
// - Inserts the wait state that covers the ROM's 1-cycle registered read, then returns instr on HRDATA.
// - Rejects writes, out-of-range and non-word transfers with a 2-cycle AHB ERROR response.
// PARAMETERS
// - ROM_DEPTH  5             number of 32-bit words implemented in the ROM
// - BASE_ADDR  32'h0000_0000 byte address of ROM word 0; must be word aligned
// PORTS
// - clk          in   1   single system clock, all logic on posedge
// - reset        in   1   asynchronous, active-high reset
// - HSEL         in   1   slave select from the bus decoder
// - HADDR        in   32  byte address, sampled in the address phase
// - HTRANS       in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// - HWRITE       in   1   1 = write (illegal for this slave)
// - HSIZE        in   3   transfer size; only 3'b010 (word) is legal
// - HREADY       in   1   bus-level ready; an address phase is valid only when high
// - HRDATA       out  32  read data; equals instr in RD_DATA, otherwise 0
// - HREADYOUT    out  1   0 = insert wait state
// - HRESP        out  1   0 OKAY, 1 ERROR
// - sel_0        out  1   ROM select; high for exactly one cycle per accepted read
// - rd_en_rom    out  1   ROM read enable; identical timing to sel_0
// - address_rom  out  32  ROM word index = (HADDR-BASE_ADDR)>>2, zero-extended
// - instr        in   32  registered ROM data, valid the cycle after rd_en_rom&&sel_0
// BEHAVIOUR
// - Reset: state IDLE; sel_0=0, rd_en_rom=0, address_rom=0, HRDATA=0, HREADYOUT=1, HRESP=0.
// - Accept: at a posedge where HSEL&&HREADY&&HTRANS[1]. BUSY and IDLE transfers get zero-wait OKAY, no ROM strobe.
// - Legal = !HWRITE && HSIZE==3'b010 && HADDR[1:0]==0 && BASE_ADDR<=HADDR && word index<ROM_DEPTH.
// - FSM states: IDLE, RD_REQ, RD_DATA, ERR1, ERR2.
// - IDLE: HREADYOUT=1, HRESP=0. Legal accept -> RD_REQ. Illegal accept -> ERR1.
// - RD_REQ: sel_0=rd_en_rom=1, address_rom=index (registered); HREADYOUT=0. Always -> RD_DATA.
// - RD_DATA: HRDATA=instr (combinational pass-through), HREADYOUT=1, HRESP=0.
//   - RD_DATA transitions: legal accept -> RD_REQ (back-to-back); illegal accept -> ERR1; else -> IDLE.
// - ERR1: HREADYOUT=0, HRESP=1, no ROM strobe. Always -> ERR2.
// - ERR2: HREADYOUT=1, HRESP=1. Accept evaluated as in RD_DATA. A master that cancels with IDLE -> IDLE.
// - Latency: each read takes 2 data-phase cycles (1 wait). Sustained rate is 1 word per 2 cycles.
// - The strobes are never asserted outside RD_REQ, so the ROM drives instr=0 at all other times.
// - The address-phase signals are ignored while HREADYOUT=0 (RD_REQ, ERR1), per AHB.
// - Index arithmetic: 32-bit subtract, then >>2. An HADDR below BASE_ADDR is out-of-range, not a wrap.
// - Reset mid-transfer (any state): immediate return to reset values; the in-flight transfer is dropped.
// STRUCTURE
// - Shared package ahb_pkg: HTRANS_* and HRESP_* codes, HSIZE_WORD, the slave FSM state enum.
// - Single flat module with no sub-module. Instantiate it beside the ROM in the AHB slave wrapper.
// TESTING
// - Reset, then read 0x0 -> 1 wait cycle, then HRDATA=AAAA_AAAA, HRESP=0.
// - Back-to-back NONSEQ 0x4 then 0x8 -> BBBB_BBBB then CCCC_CCCC, 1 wait each, no idle gap.
// - Write to 0x0 -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (1,1); sel_0/rd_en_rom stay 0.
// - Read 0x14 (index 5) or 0x2 (misaligned) -> 2-cycle ERROR, HRDATA=0.
// - BUSY or IDLE with HSEL=1 -> HREADYOUT=1, HRESP=0, no ROM strobe.
// - Assert reset during RD_REQ -> all outputs at reset values on the same cycle; next read 0xC -> DDDD_DDDD.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the ROM slave FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } ahb_slv_state_e;

endpackage

// File: rtl/ahb_rom_slave_if.sv
// AHB-Lite slave front-end for the instruction ROM: decodes transfers, strobes the ROM, returns instr.
// Latency: 2 data-phase cycles per read (1 wait state); errors take 2 cycles (ERR1 wait, ERR2 final).
// Backpressure: HREADYOUT low in RD_REQ/ERR1; address-phase inputs are ignored while it is low.
//
// Ports:
//   clk, reset                 - system clock, async active-high reset
//   HSEL/HADDR/HTRANS/HWRITE/
//   HSIZE/HREADY               - AHB-Lite address-phase inputs
//   HRDATA/HREADYOUT/HRESP     - AHB-Lite data-phase outputs
//   sel_0/rd_en_rom/address_rom- ROM strobes and word index
//   instr                      - registered ROM read data
module ahb_rom_slave_if
    import ahb_pkg::*;
#(
    parameter int          ROM_DEPTH = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        sel_0,
    output logic        rd_en_rom,
    output logic [31:0] address_rom,
    input  logic [31:0] instr
);

    ahb_slv_state_e state_q, state_d;
    logic [31:0]    addr_q, addr_d;

    logic        accept;
    logic        legal;
    logic [31:0] offset;
    logic [31:0] index;

    // Only NONSEQ/SEQ carry a transfer; IDLE and BUSY fall through as zero-wait OKAY.
    assign accept = HSEL && HREADY &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // BASE_ADDR is word aligned, so offset[1:0] equals HADDR[1:0]. The explicit
    // lower-bound check stops an address below the base wrapping into range.
    assign offset = HADDR - BASE_ADDR;
    assign index  = {2'b00, offset[31:2]};
    assign legal  = !HWRITE && (HSIZE == HSIZE_WORD) && (offset[1:0] == 2'b00) &&
                    (HADDR >= BASE_ADDR) && (index < 32'(ROM_DEPTH));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE, ST_RD_DATA, ST_ERR2: begin
                if (accept) begin
                    if (legal) begin
                        state_d = ST_RD_REQ;
                        addr_d  = index;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: state_d = ST_RD_DATA;
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        sel_0     = 1'b0;
        rd_en_rom = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = 32'd0;
        case (state_q)
            ST_RD_REQ: begin
                sel_0     = 1'b1;
                rd_en_rom = 1'b1;
                HREADYOUT = 1'b0;
            end
            ST_RD_DATA: HRDATA = instr;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    assign address_rom = addr_q;

endmodule

// File: tb/tb_ahb_rom_slave_if.sv
module tb_ahb_rom_slave_if;

    logic        clk;
    logic        reset;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        sel_0;
    logic        rd_en_rom;
    logic [31:0] address_rom;
    logic [31:0] instr;

    int total;
    int bad;

    logic [31:0] rom_mem [0:4];

    ahb_rom_slave_if #(.ROM_DEPTH(5), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .sel_0(sel_0), .rd_en_rom(rd_en_rom), .address_rom(address_rom),
        .instr(instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: drives a word the cycle after a strobe, zero otherwise.
    always @(posedge clk or posedge reset) begin
        if (reset)
            instr <= 32'd0;
        else if (sel_0 && rd_en_rom && address_rom < 32'd5)
            instr <= rom_mem[address_rom[2:0]];
        else
            instr <= 32'd0;
    end

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic [2:0] size);
        HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size; HREADY = 1'b1;
    endtask

    task automatic go_idle();
        drive(1'b0, 2'b00, 32'd0, 1'b0, 3'b010);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go_idle();
        step(); step();
        total++;
        if ({sel_0, rd_en_rom, HREADYOUT, HRESP} !== 4'b0010) begin
            bad++;
            $display("FAIL reset_ctrl: sel/rd/rdy/resp=%b want 0010", {sel_0, rd_en_rom, HREADYOUT, HRESP});
        end
        total++;
        if (address_rom !== 32'd0 || HRDATA !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: address_rom=%h HRDATA=%h want 0/0", address_rom, HRDATA);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        drive(1'b1, 2'b10, 32'h0, 1'b0, 3'b010);
        step();
        go_idle();
        total++;
        if ({sel_0, rd_en_rom, HREADYOUT} !== 3'b110 || address_rom !== 32'd0) begin
            bad++;
            $display("FAIL rd0_req: sel/rd/rdy=%b addr=%h want 110 addr 0", {sel_0, rd_en_rom, HREADYOUT}, address_rom);
        end
        step();
        total++;
        if (HRDATA !== 32'hAAAA_AAAA || HREADYOUT !== 1'b1 || HRESP !== 1'b0 || sel_0 !== 1'b0) begin
            bad++;
            $display("FAIL rd0_data: HRDATA=%h rdy=%b resp=%b sel=%b want AAAAAAAA 1 0 0", HRDATA, HREADYOUT, HRESP, sel_0);
        end
        step();
        total++;
        if (HRDATA !== 32'd0 || HREADYOUT !== 1'b1) begin
            bad++;
            $display("FAIL rd0_after: HRDATA=%h rdy=%b want 0 1", HRDATA, HREADYOUT);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b10, 32'h4, 1'b0, 3'b010);
        step();
        // Master holds the next address phase through the wait state.
        drive(1'b1, 2'b10, 32'h8, 1'b0, 3'b010);
        total++;
        if (sel_0 !== 1'b1 || address_rom !== 32'd1 || HREADYOUT !== 1'b0) begin
            bad++;
            $display("FAIL b2b_req1: sel=%b addr=%h rdy=%b want 1 1 0", sel_0, address_rom, HREADYOUT);
        end
        step();
        total++;
        if (HRDATA !== 32'hBBBB_BBBB || HREADYOUT !== 1'b1) begin
            bad++;
            $display("FAIL b2b_data1: HRDATA=%h rdy=%b want BBBBBBBB 1", HRDATA, HREADYOUT);
        end
        step();
        go_idle();
        total++;
        if (sel_0 !== 1'b1 || address_rom !== 32'd2 || HREADYOUT !== 1'b0) begin
            bad++;
            $display("FAIL b2b_req2: sel=%b addr=%h rdy=%b want 1 2 0", sel_0, address_rom, HREADYOUT);
        end
        step();
        total++;
        if (HRDATA !== 32'hCCCC_CCCC || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            bad++;
            $display("FAIL b2b_data2: HRDATA=%h rdy=%b resp=%b want CCCCCCCC 1 0", HRDATA, HREADYOUT, HRESP);
        end
        step();
    endtask

    // Runs one illegal transfer and checks the two-cycle ERROR response.
    task automatic test_error(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        drive(1'b1, 2'b10, addr, wr, size);
        step();
        go_idle();
        total++;
        if ({HREADYOUT, HRESP, sel_0, rd_en_rom} !== 4'b0100 || HRDATA !== 32'd0) begin
            bad++;
            $display("FAIL err1 addr=%h wr=%b: rdy/resp/sel/rd=%b HRDATA=%h want 0100 0",
                     addr, wr, {HREADYOUT, HRESP, sel_0, rd_en_rom}, HRDATA);
        end
        step();
        total++;
        if ({HREADYOUT, HRESP, sel_0, rd_en_rom} !== 4'b1100 || HRDATA !== 32'd0) begin
            bad++;
            $display("FAIL err2 addr=%h wr=%b: rdy/resp/sel/rd=%b HRDATA=%h want 1100 0",
                     addr, wr, {HREADYOUT, HRESP, sel_0, rd_en_rom}, HRDATA);
        end
        step();
        total++;
        if ({HREADYOUT, HRESP} !== 2'b10) begin
            bad++;
            $display("FAIL err_exit addr=%h: rdy/resp=%b want 10", addr, {HREADYOUT, HRESP});
        end
    endtask

    task automatic test_busy_idle();
        logic [1:0] kinds [0:1];
        kinds[0] = 2'b01;
        kinds[1] = 2'b00;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, kinds[k], 32'h4, 1'b0, 3'b010);
            step();
            total++;
            if ({HREADYOUT, HRESP, sel_0, rd_en_rom} !== 4'b1000) begin
                bad++;
                $display("FAIL busy_idle htrans=%b: rdy/resp/sel/rd=%b want 1000", kinds[k], {HREADYOUT, HRESP, sel_0, rd_en_rom});
            end
        end
        // A NONSEQ with bus HREADY low is not an address phase.
        drive(1'b1, 2'b10, 32'h4, 1'b0, 3'b010);
        HREADY = 1'b0;
        step();
        total++;
        if ({HREADYOUT, HRESP, sel_0} !== 3'b100) begin
            bad++;
            $display("FAIL hready_low: rdy/resp/sel=%b want 100", {HREADYOUT, HRESP, sel_0});
        end
        go_idle();
        step();
    endtask

    task automatic test_err2_then_read();
        drive(1'b1, 2'b10, 32'h0, 1'b1, 3'b010);
        step();
        drive(1'b1, 2'b10, 32'h10, 1'b0, 3'b010);
        step();
        step();
        go_idle();
        total++;
        if (sel_0 !== 1'b1 || address_rom !== 32'd4 || HRESP !== 1'b0) begin
            bad++;
            $display("FAIL err2_accept: sel=%b addr=%h resp=%b want 1 4 0", sel_0, address_rom, HRESP);
        end
        step();
        total++;
        if (HRDATA !== 32'hEEEE_EEEE) begin
            bad++;
            $display("FAIL err2_read: HRDATA=%h want EEEEEEEE", HRDATA);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 2'b10, 32'h8, 1'b0, 3'b010);
        step();
        go_idle();
        reset = 1'b1;
        #1;
        total++;
        if ({sel_0, rd_en_rom, HREADYOUT, HRESP} !== 4'b0010 || address_rom !== 32'd0 || HRDATA !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: sel/rd/rdy/resp=%b addr=%h HRDATA=%h want 0010 0 0",
                     {sel_0, rd_en_rom, HREADYOUT, HRESP}, address_rom, HRDATA);
        end
        step();
        reset = 1'b0;
        step();
        drive(1'b1, 2'b10, 32'hC, 1'b0, 3'b010);
        step();
        go_idle();
        total++;
        if (sel_0 !== 1'b1 || address_rom !== 32'd3) begin
            bad++;
            $display("FAIL post_reset_req: sel=%b addr=%h want 1 3", sel_0, address_rom);
        end
        step();
        total++;
        if (HRDATA !== 32'hDDDD_DDDD || HREADYOUT !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_data: HRDATA=%h rdy=%b want DDDDDDDD 1", HRDATA, HREADYOUT);
        end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rom_mem[0] = 32'hAAAA_AAAA;
        rom_mem[1] = 32'hBBBB_BBBB;
        rom_mem[2] = 32'hCCCC_CCCC;
        rom_mem[3] = 32'hDDDD_DDDD;
        rom_mem[4] = 32'hEEEE_EEEE;
        reset = 1'b1;
        go_idle();

        test_reset();
        test_single_read();
        test_back_to_back();
        test_error(32'h0000_0000, 1'b1, 3'b010);
        test_error(32'h0000_0014, 1'b0, 3'b010);
        test_error(32'h0000_0002, 1'b0, 3'b010);
        test_error(32'h0000_0004, 1'b0, 3'b001);
        test_busy_idle();
        test_err2_then_read();
        test_reset_mid_read();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
